// File: rtl/object_bounds.sv
// rtl/object_bounds.sv - per-label bounding box and pixel count accumulator with frame-end record dump
//
// Purpose:
//   Consumes the connected-components label stream. While accumulating, every
//   non-background labelled pixel widens its label's bounding box and bumps its
//   pixel count. A rising edge on vsync ends the frame: the table is walked in
//   ascending label order and one record per non-empty label is streamed out
//   over a valid/ready handshake. Each accepted record empties its entry, so
//   the table is clean again when accumulation resumes.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   en                    pixel-valid qualifier
//   vsync                 frame sync, rising edge = frame end
//   x, y                  coordinates of the current label
//   label                 current label (0 = background)
//   out_valid, out_ready  record handshake
//   out_label             label of the presented record
//   out_x_min, out_x_max  horizontal extent of the label
//   out_y_min, out_y_max  vertical extent of the label
//   out_count             pixel count, saturating
//   busy                  high while the table is being dumped
//   overflow              sticky, a label >= MAX_LABELS was seen this frame
module object_bounds #(
  parameter int LABEL_WIDTH = 8,
  parameter int MAX_LABELS  = 64,
  parameter int COORD_WIDTH = 10,
  parameter int COUNT_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   vsync,
  input  logic [COORD_WIDTH-1:0] x,
  input  logic [COORD_WIDTH-1:0] y,
  input  logic [LABEL_WIDTH-1:0] label,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LABEL_WIDTH-1:0] out_label,
  output logic [COORD_WIDTH-1:0] out_x_min,
  output logic [COORD_WIDTH-1:0] out_x_max,
  output logic [COORD_WIDTH-1:0] out_y_min,
  output logic [COORD_WIDTH-1:0] out_y_max,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   busy,
  output logic                   overflow
);

  localparam int IDX_W = $clog2(MAX_LABELS);
  localparam int LW1   = LABEL_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MAX_LABELS - 1);
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
  localparam logic [COUNT_WIDTH-1:0] ONE_COUNT = COUNT_WIDTH'(1);

  typedef enum logic {ACCUM, DUMP} state_t;

  state_t state;
  state_t state_next;

  // Label table. Valid bits carry reset; the payload is only ever read when
  // its valid bit is set, so it needs none.
  logic [MAX_LABELS-1:0]  tbl_valid;
  logic [COORD_WIDTH-1:0] tbl_x_min [MAX_LABELS];
  logic [COORD_WIDTH-1:0] tbl_x_max [MAX_LABELS];
  logic [COORD_WIDTH-1:0] tbl_y_min [MAX_LABELS];
  logic [COORD_WIDTH-1:0] tbl_y_max [MAX_LABELS];
  logic [COUNT_WIDTH-1:0] tbl_count [MAX_LABELS];

  logic [IDX_W-1:0] idx;
  logic             vsync_d;
  logic             frame_end;

  // Pixel update path
  logic             in_range;
  logic             pix_hit;
  logic             pix_oor;
  logic [IDX_W-1:0] pidx;
  logic             cur_valid;
  logic [COORD_WIDTH-1:0] new_x_min;
  logic [COORD_WIDTH-1:0] new_x_max;
  logic [COORD_WIDTH-1:0] new_y_min;
  logic [COORD_WIDTH-1:0] new_y_max;
  logic [COUNT_WIDTH-1:0] new_count;

  // Dump control
  logic             accept;
  logic             load;
  logic [IDX_W-1:0] load_idx;
  logic             bypass;
  logic             ld_valid;
  logic [COORD_WIDTH-1:0] ld_x_min;
  logic [COORD_WIDTH-1:0] ld_x_max;
  logic [COORD_WIDTH-1:0] ld_y_min;
  logic [COORD_WIDTH-1:0] ld_y_max;
  logic [COUNT_WIDTH-1:0] ld_count;

  assign frame_end = vsync & ~vsync_d;
  assign in_range  = ({1'b0, label} < LW1'(MAX_LABELS));
  assign pidx      = label[IDX_W-1:0];
  assign cur_valid = tbl_valid[pidx];

  always_comb begin
    pix_hit = 1'b0;
    pix_oor = 1'b0;
    if (state == ACCUM && en && label != '0) begin
      pix_hit = in_range;
      pix_oor = ~in_range;
    end
  end

  // A fresh entry starts as a single-pixel box; an existing one is widened.
  always_comb begin
    new_x_min = x;
    new_x_max = x;
    new_y_min = y;
    new_y_max = y;
    new_count = ONE_COUNT;
    if (cur_valid) begin
      new_x_min = (x < tbl_x_min[pidx]) ? x : tbl_x_min[pidx];
      new_x_max = (x > tbl_x_max[pidx]) ? x : tbl_x_max[pidx];
      new_y_min = (y < tbl_y_min[pidx]) ? y : tbl_y_min[pidx];
      new_y_max = (y > tbl_y_max[pidx]) ? y : tbl_y_max[pidx];
      new_count = (&tbl_count[pidx]) ? tbl_count[pidx] : tbl_count[pidx] + ONE_COUNT;
    end
  end

  // Next-state and dump sequencing. The output register always holds the
  // entry at idx, loaded one cycle ahead, so out_valid stays registered while
  // still allowing one record per cycle under continuous out_ready.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    load       = 1'b0;
    load_idx   = idx + FIRST_IDX;
    case (state)
      ACCUM: begin
        if (frame_end) begin
          state_next = DUMP;
          load       = 1'b1;
          load_idx   = FIRST_IDX;
        end
      end
      DUMP: begin
        accept = out_valid & out_ready;
        if (!out_valid || out_ready) begin
          if (idx == LAST_IDX) begin
            state_next = ACCUM;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  // A pixel landing on entry 1 in the frame-end cycle has not reached the
  // table yet, so the first lookahead load takes the freshly computed values.
  always_comb begin
    bypass   = pix_hit && (pidx == load_idx);
    ld_valid = bypass | tbl_valid[load_idx];
    ld_x_min = bypass ? new_x_min : tbl_x_min[load_idx];
    ld_x_max = bypass ? new_x_max : tbl_x_max[load_idx];
    ld_y_min = bypass ? new_y_min : tbl_y_min[load_idx];
    ld_y_max = bypass ? new_y_max : tbl_y_max[load_idx];
    ld_count = bypass ? new_count : tbl_count[load_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ACCUM;
      vsync_d   <= 1'b0;
      tbl_valid <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_label <= '0;
      out_x_min <= '0;
      out_x_max <= '0;
      out_y_min <= '0;
      out_y_max <= '0;
      out_count <= '0;
    end else begin
      state   <= state_next;
      vsync_d <= vsync;
      busy    <= (state_next == DUMP);

      if (pix_hit) begin
        tbl_valid[pidx] <= 1'b1;
      end
      if (accept) begin
        tbl_valid[idx] <= 1'b0;
      end

      if (pix_oor) begin
        overflow <= 1'b1;
      end else if (state == DUMP && state_next == ACCUM) begin
        overflow <= 1'b0;
      end

      if (load) begin
        idx       <= load_idx;
        out_valid <= ld_valid;
        out_label <= LABEL_WIDTH'(load_idx);
        out_x_min <= ld_x_min;
        out_x_max <= ld_x_max;
        out_y_min <= ld_y_min;
        out_y_max <= ld_y_max;
        out_count <= ld_count;
      end else if (state_next == ACCUM) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pix_hit) begin
      tbl_x_min[pidx] <= new_x_min;
      tbl_x_max[pidx] <= new_x_max;
      tbl_y_min[pidx] <= new_y_min;
      tbl_y_max[pidx] <= new_y_max;
      tbl_count[pidx] <= new_count;
    end
  end

endmodule

// File: tb/tb_object_bounds.sv
// tb/tb_object_bounds.sv - self-checking bench for object_bounds
module tb_object_bounds;

  localparam int LW = 8;
  localparam int ML = 64;
  localparam int CW = 10;
  localparam int NW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          vsync;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic [LW-1:0] label;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_label;
  logic [CW-1:0] out_x_min;
  logic [CW-1:0] out_x_max;
  logic [CW-1:0] out_y_min;
  logic [CW-1:0] out_y_max;
  logic [NW-1:0] out_count;
  logic          busy;
  logic          overflow;

  always #5 clk = ~clk;

  object_bounds #(
    .LABEL_WIDTH(LW),
    .MAX_LABELS (ML),
    .COORD_WIDTH(CW),
    .COUNT_WIDTH(NW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .vsync    (vsync),
    .x        (x),
    .y        (y),
    .label    (label),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_label(out_label),
    .out_x_min(out_x_min),
    .out_x_max(out_x_max),
    .out_y_min(out_y_min),
    .out_y_max(out_y_max),
    .out_count(out_count),
    .busy     (busy),
    .overflow (overflow)
  );

  typedef struct {
    int lbl;
    int xmin;
    int xmax;
    int ymin;
    int ymax;
    int cnt;
  } rec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Frame model: per-label box and count, plus the records a dump must yield.
  bit   m_valid [ML];
  int   m_xmin  [ML];
  int   m_xmax  [ML];
  int   m_ymin  [ML];
  int   m_ymax  [ML];
  int   m_cnt   [ML];
  bit   m_ovf = 1'b0;
  bit   dump_ovf = 1'b0;
  rec_t exp_q [$];

  int   rec_cnt = 0;
  rec_t last;
  rec_t held;
  bit   stall = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic void model_pix(input int px, input int py, input int l);
    if (l == 0) return;
    if (l >= ML) begin
      m_ovf = 1'b1;
      return;
    end
    if (!m_valid[l]) begin
      m_valid[l] = 1'b1;
      m_xmin[l] = px; m_xmax[l] = px;
      m_ymin[l] = py; m_ymax[l] = py;
      m_cnt[l]  = 1;
    end else begin
      if (px < m_xmin[l]) m_xmin[l] = px;
      if (px > m_xmax[l]) m_xmax[l] = px;
      if (py < m_ymin[l]) m_ymin[l] = py;
      if (py > m_ymax[l]) m_ymax[l] = py;
      if (m_cnt[l] < (1 << NW) - 1) m_cnt[l] = m_cnt[l] + 1;
    end
  endfunction

  function automatic void model_frame_end();
    rec_t r;
    exp_q.delete();
    for (int l = 1; l < ML; l++) begin
      if (m_valid[l]) begin
        r.lbl = l; r.xmin = m_xmin[l]; r.xmax = m_xmax[l];
        r.ymin = m_ymin[l]; r.ymax = m_ymax[l]; r.cnt = m_cnt[l];
        exp_q.push_back(r);
        m_valid[l] = 1'b0;
      end
    end
    dump_ovf = m_ovf;
    m_ovf = 1'b0;
  endfunction

  // Compare process: checks every handshake against the model, record
  // stability while stalled, overflow during the dump and idle out_valid.
  always @(negedge clk) begin
    rec_t r;
    if (reset) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_label", out_label, held.lbl);
        check("hold_x_min", out_x_min, held.xmin);
        check("hold_x_max", out_x_max, held.xmax);
        check("hold_y_min", out_y_min, held.ymin);
        check("hold_y_max", out_y_max, held.ymax);
        check("hold_count", out_count, held.cnt);
      end
      if (busy) check("dump_overflow", overflow, dump_ovf);
      else      check("idle_out_valid", out_valid, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL extra_record: got label %0d, expected no record", out_label);
        end else begin
          r = exp_q.pop_front();
          check("rec_label", out_label, r.lbl);
          check("rec_x_min", out_x_min, r.xmin);
          check("rec_x_max", out_x_max, r.xmax);
          check("rec_y_min", out_y_min, r.ymin);
          check("rec_y_max", out_y_max, r.ymax);
          check("rec_count", out_count, r.cnt);
        end
        rec_cnt++;
        last.lbl = out_label; last.xmin = out_x_min; last.xmax = out_x_max;
        last.ymin = out_y_min; last.ymax = out_y_max; last.cnt = out_count;
      end
      stall = out_valid && !out_ready;
      if (stall) begin
        held.lbl = out_label; held.xmin = out_x_min; held.xmax = out_x_max;
        held.ymin = out_y_min; held.ymax = out_y_max; held.cnt = out_count;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int px, input int py, input int l);
    en = 1'b1; x = CW'(px); y = CW'(py); label = LW'(l);
    model_pix(px, py, l);
    step();
    en = 1'b0;
  endtask

  task automatic gap(input int n);
    en = 1'b0;
    repeat (n) step();
  endtask

  task automatic frame_end(input bit with_pix, input int px, input int py, input int l);
    if (with_pix) begin
      en = 1'b1; x = CW'(px); y = CW'(py); label = LW'(l);
      model_pix(px, py, l);
    end
    vsync = 1'b1;
    model_frame_end();
    rec_cnt = 0;
    step();
    en = 1'b0;
    vsync = 1'b0;
  endtask

  // Waits for the dump to finish; n0 is the number of DUMP cycles already spent.
  task automatic wait_dump(input string name, input int exp_n, input int n0);
    int n;
    n = n0;
    while (busy && n < 500) begin
      step();
      n++;
    end
    check({name, "_done"}, busy, 0);
    if (exp_n >= 0) check({name, "_cycles"}, n, exp_n);
    check({name, "_left"}, exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    check(name, out_valid, 1);
  endtask

  task automatic check_last(input string name, input int l, input int x0, input int x1,
                            input int y0, input int y1, input int c);
    check({name, "_label"}, last.lbl, l);
    check({name, "_x_min"}, last.xmin, x0);
    check({name, "_x_max"}, last.xmax, x1);
    check({name, "_y_min"}, last.ymin, y0);
    check({name, "_y_max"}, last.ymax, y1);
    check({name, "_count"}, last.cnt, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en = 1'b0; vsync = 1'b0; x = '0; y = '0; label = '0; out_ready = 1'b0;
    step();
    step();
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_overflow", overflow, 0);
    check("reset_out_label", out_label, 0);
    check("reset_out_count", out_count, 0);
    reset = 1'b0;
    step();

    // Single pixel
    out_ready = 1'b1;
    pixel(10, 4, 3);
    gap(2);
    frame_end(1'b0, 0, 0, 0);
    wait_dump("t1", 63, 0);
    check("t1_records", rec_cnt, 1);
    check_last("t1", 3, 10, 10, 4, 4, 1);

    // 5x3 rectangle with back-to-back runs and gaps
    for (int yy = 2; yy <= 4; yy++) begin
      for (int xx = 20; xx <= 24; xx++) begin
        pixel(xx, yy, 7);
        if (xx == 21) gap(1);
      end
      gap(2);
    end
    frame_end(1'b0, 0, 0, 0);
    wait_dump("t2", 63, 0);
    check("t2_records", rec_cnt, 1);
    check_last("t2", 7, 20, 24, 2, 4, 15);

    // Two labels, stalled consumer, then an empty frame
    out_ready = 1'b0;
    pixel(5, 5, 2);
    pixel(6, 5, 9);
    pixel(7, 6, 2);
    pixel(3, 8, 9);
    gap(1);
    frame_end(1'b0, 0, 0, 0);
    wait_valid("t3_valid_rise");
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_label", out_label, 2);
      check("t3_stall_count", out_count, 2);
      step();
    end
    out_ready = 1'b1;
    wait_dump("t3", -1, 0);
    check("t3_records", rec_cnt, 2);
    check_last("t3", 9, 3, 6, 5, 8, 2);
    gap(2);
    frame_end(1'b0, 0, 0, 0);
    wait_dump("t3_empty", 63, 0);
    check("t3_empty_records", rec_cnt, 0);

    // Out-of-range label, plus a label-1 pixel in the frame-end cycle
    pixel(3, 3, 70);
    check("t4_ovf_accum", overflow, 1);
    gap(1);
    frame_end(1'b1, 50, 60, 1);
    wait_dump("t4", 63, 0);
    check("t4_ovf_after", overflow, 0);
    check("t4_records", rec_cnt, 1);
    check_last("t4", 1, 50, 50, 60, 60, 1);

    // Pixels and a vsync edge injected during the dump
    pixel(100, 200, 12);
    gap(1);
    frame_end(1'b0, 0, 0, 0);
    en = 1'b1; x = CW'(1); y = CW'(1); label = LW'(4);
    step();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
    en = 1'b0;
    wait_dump("t5", 63, 3);
    check("t5_records", rec_cnt, 1);
    check_last("t5", 12, 100, 100, 200, 200, 1);
    gap(2);
    frame_end(1'b0, 0, 0, 0);
    wait_dump("t5_next", 63, 0);
    check("t5_next_records", rec_cnt, 0);

    // Reset while a record is stalled
    out_ready = 1'b0;
    pixel(8, 9, 2);
    gap(1);
    frame_end(1'b0, 0, 0, 0);
    wait_valid("t6_valid_rise");
    step();
    reset = 1'b1;
    #1;
    check("t6_reset_out_valid", out_valid, 0);
    check("t6_reset_busy", busy, 0);
    exp_q.delete();
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    pixel(30, 31, 5);
    pixel(31, 33, 5);
    gap(1);
    frame_end(1'b0, 0, 0, 0);
    wait_dump("t6", 63, 0);
    check("t6_records", rec_cnt, 1);
    check_last("t6", 5, 30, 31, 31, 33, 2);

    gap(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/object_bounds.md
Name: object_bounds

Overview:
- Downstream consumer of the connected-components label stream; sits after connected_components_labeling in top.
- Accumulates per-label bounding box (x/y min/max) and pixel count across a frame.
- At frame end (vsync rising edge), streams one record per non-empty label over a valid/ready interface, then re-arms for the next frame.

Parameters:
- LABEL_WIDTH, 8, width of the incoming label (matches `WORD_SIZE).
- MAX_LABELS, 64, table entries; labels 1..MAX_LABELS-1 are tracked, 0 is background.
- COORD_WIDTH, 10, width of x/y coordinates (low bits of location_generator x/y).
- COUNT_WIDTH, 20, width of the per-label pixel counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  pixel-valid qualifier, same as the pipeline en.
- vsync  input  1  frame sync; its rising edge marks frame end.
- x  input  COORD_WIDTH  column of the current label.
- y  input  COORD_WIDTH  row of the current label.
- label  input  LABEL_WIDTH  connected-components output (cc_out).
- out_valid  output  1  record valid.
- out_ready  input  1  consumer accepts record.
- out_label  output  LABEL_WIDTH  label of record.
- out_x_min, out_x_max  output  COORD_WIDTH  horizontal extent.
- out_y_min, out_y_max  output  COORD_WIDTH  vertical extent.
- out_count  output  COUNT_WIDTH  pixel count, saturating.
- busy  output  1  high while in DUMP.
- overflow  output  1  sticky: a label >= MAX_LABELS was seen this frame.

Behaviour:
- Reset: state ACCUM, all table valid bits 0, vsync edge register 0, all outputs 0.
- Table: per entry valid bit, x_min, x_max, y_min, y_max, count. Register array; read is combinational, write is registered.
- Frame-end detection: vsync_d registered every clk. Frame-end event = vsync & ~vsync_d. This edge counts only in ACCUM; edges in DUMP are ignored.
- ACCUM, with en=1 and label != 0:
  - label < MAX_LABELS, entry invalid: set min=max=x, min=max=y, count=1, valid=1.
  - label < MAX_LABELS, entry valid: min/max updated by unsigned compare; count+1, saturating at all-ones.
  - label >= MAX_LABELS: no table write; overflow <= 1.
- Update is visible the next cycle. Back-to-back pixels with the same label must accumulate with no lost update. Example: two consecutive cycles on label 5 give count +2.
- en=0 or label=0: no table change.
- ACCUM -> DUMP on a frame-end event. If a pixel update is in the same cycle, it is applied first. idx <= 1, busy <= 1.
- DUMP, per cycle:
  - If entry[idx] is invalid: skip, idx+1.
  - If valid: present the record. Hold out_valid=1 and all out_* fields stable until out_ready=1. On the accept cycle, clear entry[idx].valid and advance idx.
  - Records are emitted in ascending label order.
  - Pixels arriving in DUMP are dropped (no table write, no overflow).
- DUMP -> ACCUM after idx = MAX_LABELS-1 is processed (accepted or skipped). On that transition, busy <= 0 and overflow <= 0.
- overflow is readable throughout DUMP.
- out_valid is registered and never combinationally dependent on out_ready. out_valid=1 with out_ready=1 on consecutive cycles sustains one record per cycle when entries are contiguous.
- No valid entries at frame end: DUMP walks the table with out_valid=0, taking MAX_LABELS-1 cycles, then returns to ACCUM.
- Reset asserted mid-DUMP: immediate return to the reset state. The pending record is lost and out_valid drops asynchronously.

Test Plan:
- Single pixel label=3 at (x=10,y=4), then vsync edge, out_ready=1: exactly one record {label 3, x 10..10, y 4..4, count 1}. busy falls after 63 DUMP cycles.
- Label 7 painted over a 5x3 rectangle at x 20..24, y 2..4, row-major with gaps of en=0: record {7, x 20..24, y 2..4, count 15}. Back-to-back same-label cycles lose no counts.
- Labels 2 and 9 present, out_ready held low 5 cycles after out_valid rises: label 2 record stable for all 5 cycles. Order is 2 then 9. A second frame with no pixels emits no records.
- label=70 with MAX_LABELS=64: overflow=1 during DUMP, table unchanged, overflow=0 after returning to ACCUM.
- Pixels (label 4) and a second vsync edge injected during DUMP: no effect on records or state. The following frame starts with an empty table.
- reset pulsed while label 2 record is stalled with out_valid=1: out_valid=0, busy=0 immediately. The next frame reports only that frame's pixels.
